// File: rtl/mest_pro_display_scan_pkg.sv
// -----------------------------------------------------------------------------
// mest_pro_display_scan_pkg
//   Shared definitions for the MEST Pro seven-segment scan controller:
//   scan FSM state encoding, segment bit positions on the segment bus,
//   default interval lengths, and a small elaboration-time helper.
// -----------------------------------------------------------------------------
package mest_pro_display_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_FETCH = 2'd2,
        ST_SHOW  = 2'd3
    } scan_state_t;

    // Segment bus bit positions: segment a is the MSB, segment g the LSB.
    localparam int SEG_A_BIT = 6;
    localparam int SEG_B_BIT = 5;
    localparam int SEG_C_BIT = 4;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 2;
    localparam int SEG_F_BIT = 1;
    localparam int SEG_G_BIT = 0;

    localparam int DEFAULT_SHOW_CYCLES  = 1000;
    localparam int DEFAULT_BLANK_CYCLES = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mest_pro_scan_timer.sv
// -----------------------------------------------------------------------------
// mest_pro_scan_timer
//   Loadable down-counter shared by the BLANK and SHOW intervals.
//   Loading N makes tc assert in the N-th cycle after the load edge, so an
//   interval that is loaded on entry and left when tc is seen lasts exactly
//   N clocks. The counter parks at zero once exhausted.
//
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-high reset (count cleared)
//     load       load load_value this cycle (has priority over counting)
//     load_value interval length in clocks (>=1)
//     count_en   decrement this cycle
//     tc         terminal count: current cycle is the last of the interval
// -----------------------------------------------------------------------------
module mest_pro_scan_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             count_en,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count_en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign tc = (count == CNT_W'(1));

endmodule

// File: rtl/mest_pro_display_scan.sv
// -----------------------------------------------------------------------------
// mest_pro_display_scan
//   Time-multiplexed scan controller for a multi-digit seven-segment display.
//   A packed value is accepted on a valid/ready port into a pending buffer and
//   promoted to the active buffer only at frame boundaries (or while idle), so
//   every frame shows digits from a single load. Each digit slot is:
//   BLANK (all dark) -> FETCH (2 clocks, shared external decoder) -> SHOW.
//
//   Optional build macro:
//     MEST_PRO_LEAD_ZERO_BLANK_EN  suppress o_digit_en (and o_seg) for digits
//                                  above the highest nonzero digit; digit 0 is
//                                  always lit. Slot timing is unchanged.
//
//   Ports:
//     clk             rising-edge clock
//     rst             asynchronous active-high reset
//     i_output_enable scan enable; low returns to IDLE with a dark display
//     i_load_valid    new packed value offered
//     o_load_ready    pending buffer empty
//     i_load_value    packed digits, digit 0 in the LSBs
//     o_digit_val     digit value presented to the shared decoder
//     i_seg           decoder output, valid one clock after o_digit_val
//     o_seg           registered segment drive (bit 6 = a ... bit 0 = g)
//     o_digit_en      one-hot digit select, active-high
//     o_frame_done    one-clock pulse after the last digit's SHOW interval
// -----------------------------------------------------------------------------
module mest_pro_display_scan
    import mest_pro_display_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_WIDTH  = 4,
    parameter int SEG_WIDTH    = 7,
    parameter int SHOW_CYCLES  = DEFAULT_SHOW_CYCLES,
    parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_output_enable,
    input  logic                              i_load_valid,
    output logic                              o_load_ready,
    input  logic [NUM_DIGITS*DIGIT_WIDTH-1:0] i_load_value,
    output logic [DIGIT_WIDTH-1:0]            o_digit_val,
    input  logic [SEG_WIDTH-1:0]              i_seg,
    output logic [SEG_WIDTH-1:0]              o_seg,
    output logic [NUM_DIGITS-1:0]             o_digit_en,
    output logic                              o_frame_done
);

    localparam int VALUE_W = NUM_DIGITS * DIGIT_WIDTH;
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_W   = $clog2(max_int(SHOW_CYCLES, BLANK_CYCLES) + 1);

    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SHOW_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t state, state_next;

    logic [IDX_W-1:0]      index, index_next;
    logic                  fetch_phase, fetch_phase_next;
    logic [DIGIT_WIDTH-1:0] digit_val_next;
    logic [SEG_WIDTH-1:0]  seg_next;
    logic [NUM_DIGITS-1:0] digit_en_next;
    logic                  frame_done_next;

    logic [VALUE_W-1:0]    active_buf, active_next;
    logic [VALUE_W-1:0]    pending_buf;
    logic                  pending_full;
    logic                  load_fire;
    logic                  xfer;

    logic [NUM_DIGITS-1:0] lit_mask;

    logic                  tmr_load;
    logic [CNT_W-1:0]      tmr_value;
    logic                  tmr_count_en;
    logic                  tmr_tc;

    mest_pro_scan_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_value),
        .count_en   (tmr_count_en),
        .tc         (tmr_tc)
    );

    // Load port and frame-boundary buffer promotion.
    // load_fire needs an empty pending buffer and xfer needs a full one, so
    // the two never coincide: a load taken on the o_frame_done cycle waits
    // in pending for the following boundary.
    assign o_load_ready = ~pending_full;
    assign load_fire    = i_load_valid & ~pending_full;
    assign xfer         = pending_full & ((state == ST_IDLE) | o_frame_done);
    // The first BLANK of a frame can be a single clock, so the digit fetch
    // must see the value being promoted on that same edge.
    assign active_next  = xfer ? pending_buf : active_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_buf  <= '0;
            pending_full <= 1'b0;
            active_buf   <= '0;
        end else begin
            if (load_fire) begin
                pending_buf <= i_load_value;
            end
            if (load_fire) begin
                pending_full <= 1'b1;
            end else if (xfer) begin
                pending_full <= 1'b0;
            end
            active_buf <= active_next;
        end
    end

    // Which digit slots may light up for the current active value.
`ifdef MEST_PRO_LEAD_ZERO_BLANK_EN
    logic seen_nonzero;

    always_comb begin
        lit_mask     = '0;
        seen_nonzero = 1'b0;
        // Scan from the top digit down; once a nonzero digit is seen every
        // lower digit is significant.
        for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
            if (active_buf[d*DIGIT_WIDTH +: DIGIT_WIDTH] != '0) begin
                seen_nonzero = 1'b1;
            end
            lit_mask[d] = seen_nonzero;
        end
        lit_mask[0] = 1'b1;
    end
`else
    always_comb begin
        lit_mask = '1;
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and next registered outputs.
    always_comb begin
        state_next       = state;
        index_next       = index;
        fetch_phase_next = 1'b0;
        digit_val_next   = o_digit_val;
        seg_next         = o_seg;
        digit_en_next    = o_digit_en;
        frame_done_next  = 1'b0;
        tmr_load         = 1'b0;
        tmr_value        = BLANK_LOAD;
        tmr_count_en     = 1'b0;

        if (!i_output_enable) begin
            state_next    = ST_IDLE;
            index_next    = '0;
            seg_next      = '0;
            digit_en_next = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_next    = ST_BLANK;
                    index_next    = '0;
                    seg_next      = '0;
                    digit_en_next = '0;
                    tmr_load      = 1'b1;
                    tmr_value     = BLANK_LOAD;
                end

                ST_BLANK: begin
                    tmr_count_en = 1'b1;
                    if (tmr_tc) begin
                        state_next     = ST_FETCH;
                        digit_val_next = active_next[int'(index)*DIGIT_WIDTH +: DIGIT_WIDTH];
                    end
                end

                ST_FETCH: begin
                    if (!fetch_phase) begin
                        fetch_phase_next = 1'b1;
                    end else begin
                        // Decoder output for o_digit_val is valid now.
                        state_next = ST_SHOW;
                        tmr_load   = 1'b1;
                        tmr_value  = SHOW_LOAD;
                        if (lit_mask[index]) begin
                            seg_next      = i_seg;
                            digit_en_next = NUM_DIGITS'(1) << index;
                        end else begin
                            seg_next      = '0;
                            digit_en_next = '0;
                        end
                    end
                end

                ST_SHOW: begin
                    tmr_count_en = 1'b1;
                    if (tmr_tc) begin
                        state_next    = ST_BLANK;
                        seg_next      = '0;
                        digit_en_next = '0;
                        tmr_load      = 1'b1;
                        tmr_value     = BLANK_LOAD;
                        if (index == LAST_IDX) begin
                            index_next      = '0;
                            frame_done_next = 1'b1;
                        end else begin
                            index_next = index + IDX_W'(1);
                        end
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Registered scan outputs and datapath state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index        <= '0;
            fetch_phase  <= 1'b0;
            o_digit_val  <= '0;
            o_seg        <= '0;
            o_digit_en   <= '0;
            o_frame_done <= 1'b0;
        end else begin
            index        <= index_next;
            fetch_phase  <= fetch_phase_next;
            o_digit_val  <= digit_val_next;
            o_seg        <= seg_next;
            o_digit_en   <= digit_en_next;
            o_frame_done <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_mest_pro_display_scan.sv
// -----------------------------------------------------------------------------
// tb_mest_pro_display_scan
//   Scoreboard bench: the stimulus process pushes the expected lit-digit
//   events (digit enable, digit value, segments) for each frame it causes;
//   a negedge monitor pops and compares whenever a digit lights up, and also
//   checks lit length, dark gap, dark segments and the frame_done pulse width.
//   A registered hex-to-seven-segment decoder stands in for the external one.
// -----------------------------------------------------------------------------
module tb_mest_pro_display_scan;

    localparam int ND    = 4;
    localparam int DW    = 4;
    localparam int SW    = 7;
    localparam int SHOW  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 48;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_output_enable = 1'b0;
    logic          i_load_valid = 1'b0;
    logic          o_load_ready;
    logic [15:0]   i_load_value = '0;
    logic [DW-1:0] o_digit_val;
    logic [SW-1:0] i_seg = '0;
    logic [SW-1:0] o_seg;
    logic [ND-1:0] o_digit_en;
    logic          o_frame_done;

    always #5 clk = ~clk;

    mest_pro_display_scan #(
        .NUM_DIGITS   (ND),
        .DIGIT_WIDTH  (DW),
        .SEG_WIDTH    (SW),
        .SHOW_CYCLES  (SHOW),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_output_enable (i_output_enable),
        .i_load_valid    (i_load_valid),
        .o_load_ready    (o_load_ready),
        .i_load_value    (i_load_value),
        .o_digit_val     (o_digit_val),
        .i_seg           (i_seg),
        .o_seg           (o_seg),
        .o_digit_en      (o_digit_en),
        .o_frame_done    (o_frame_done)
    );

    // External registered decoder (a = bit 6 ... g = bit 0).
    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h7E; 4'h1: hex7 = 7'h30; 4'h2: hex7 = 7'h6D; 4'h3: hex7 = 7'h79;
            4'h4: hex7 = 7'h33; 4'h5: hex7 = 7'h5B; 4'h6: hex7 = 7'h5F; 4'h7: hex7 = 7'h70;
            4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h7B; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h1F;
            4'hC: hex7 = 7'h4E; 4'hD: hex7 = 7'h3D; 4'hE: hex7 = 7'h4F; default: hex7 = 7'h47;
        endcase
    endfunction

    always @(posedge clk) i_seg <= hex7(o_digit_val);

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] val;
        logic [6:0] seg;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  gap_chk = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input logic [3:0] en, input logic [3:0] val, input logic [6:0] seg);
        ev_t e;
        e.en  = en;
        e.val = val;
        e.seg = seg;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input logic [3:0] v0, input logic [6:0] s0,
                              input logic [3:0] v1, input logic [6:0] s1,
                              input logic [3:0] v2, input logic [6:0] s2,
                              input logic [3:0] v3, input logic [6:0] s3);
        push_ev(4'b0001, v0, s0);
        push_ev(4'b0010, v1, s1);
        push_ev(4'b0100, v2, s2);
        push_ev(4'b1000, v3, s3);
    endtask

    // Monitor
    logic [3:0] prev_en = '0;
    logic [6:0] lit_seg = '0;
    logic       prev_fd = 1'b0;
    int         lit_len = 0;
    int         dark_len = 0;
    bit         gap_valid = 1'b0;
    ev_t        mon_ev;

    always @(negedge clk) begin
        if (rst) begin
            prev_en   = '0;
            prev_fd   = 1'b0;
            lit_len   = 0;
            dark_len  = 0;
            gap_valid = 1'b0;
        end else begin
            if (o_digit_en != '0 && prev_en == '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_lit: got en=%b val=%h seg=%h expected no lit digit at %0t",
                             o_digit_en, o_digit_val, o_seg, $time);
                end else begin
                    mon_ev = exp_q.pop_front();
                    check("lit_digit_en", o_digit_en, mon_ev.en);
                    check("lit_digit_val", o_digit_val, mon_ev.val);
                    check("lit_seg", o_seg, mon_ev.seg);
                end
                if (gap_valid && gap_chk) check("dark_gap_len", dark_len, BLANK + 2);
                lit_len = 1;
                lit_seg = o_seg;
            end else if (o_digit_en != '0) begin
                lit_len++;
                check("seg_hold", o_seg, lit_seg);
            end else begin
                if (prev_en != '0) begin
                    if (i_output_enable) check("lit_len", lit_len, SHOW);
                    gap_valid = i_output_enable;
                    dark_len  = 0;
                end
                dark_len++;
                check("dark_seg", o_seg, 0);
            end
            if (!i_output_enable) gap_valid = 1'b0;
            if (o_frame_done) check("frame_done_one_clock", prev_fd, 0);
            prev_fd = o_frame_done;
            prev_en = o_digit_en;
        end
    end

    task automatic wait_cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_fd(output int n);
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (o_frame_done) begin
                n = k;
                break;
            end
        end
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_done_timeout: got no pulse expected one within 200 clocks");
        end
    endtask

    task automatic do_load(input logic [15:0] v, output int stall, output bit fd_seen);
        bit done;
        stall        = 0;
        fd_seen      = 1'b0;
        done         = 1'b0;
        i_load_valid = 1'b1;
        i_load_value = v;
        for (int n = 0; n < 200; n++) begin
            if (o_frame_done) fd_seen = 1'b1;
            if (o_load_ready) done = 1'b1;
            else stall++;
            @(posedge clk);
            #1;
            if (done) break;
        end
        i_load_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: got ready=0 expected acceptance for %h", v);
        end
    endtask

    // Enable and measure first-lit and frame_done offsets from the first
    // enabled clock edge.
    task automatic enable_and_time(input string tag);
        int first_lit;
        int fd_at;
        first_lit       = 0;
        fd_at           = 0;
        i_output_enable = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (first_lit == 0 && o_digit_en[0]) first_lit = k;
            if (o_frame_done) begin
                fd_at = k;
                break;
            end
        end
        check({tag, "_first_lit"}, first_lit - 1, BLANK + 2);
        check({tag, "_frame_done"}, fd_at - 1, FRAME);
    endtask

    int stall;
    bit fd_seen;
    int fd_n;

    initial begin
        // Reset state
        wait_cyc(3);
        check("rst_digit_en", o_digit_en, 0);
        check("rst_seg", o_seg, 0);
        check("rst_digit_val", o_digit_val, 0);
        check("rst_frame_done", o_frame_done, 0);
        check("rst_load_ready", o_load_ready, 1);
        rst = 1'b0;
        wait_cyc(1);

        // 0x1234, loaded while idle
        do_load(16'h1234, stall, fd_seen);
        check("idle_load_stall", stall, 0);
        check("ready_drop", o_load_ready, 0);
        wait_cyc(2);
        check("idle_promote_ready", o_load_ready, 1);
        push_frame(4'h4, 7'h33, 4'h3, 7'h79, 4'h2, 7'h6D, 4'h1, 7'h30);
        enable_and_time("frame1");
        push_frame(4'h4, 7'h33, 4'h3, 7'h79, 4'h2, 7'h6D, 4'h1, 7'h30);

        // Back-to-back loads mid-frame
        wait_cyc(20);
        do_load(16'hAAAA, stall, fd_seen);
        check("aaaa_stall", stall, 0);
        push_frame(4'hA, 7'h77, 4'hA, 7'h77, 4'hA, 7'h77, 4'hA, 7'h77);
        do_load(16'h5555, stall, fd_seen);
        check("b2b_stalled", (stall > 0), 1);
        check("b2b_waits_frame_done", fd_seen, 1);
        push_frame(4'h5, 7'h5B, 4'h5, 7'h5B, 4'h5, 7'h5B, 4'h5, 7'h5B);
        wait_fd(fd_n);
        push_ev(4'b0001, 4'h5, 7'h5B);
        push_ev(4'b0010, 4'h5, 7'h5B);
        wait_fd(fd_n);

        // Drop enable in FETCH of digit 2
        wait_cyc(26);
        check("fetch2_digit_val", o_digit_val, 4'h5);
        check("fetch2_dark", o_digit_en, 0);
        i_output_enable = 1'b0;
        wait_cyc(1);
        check("disable_digit_en", o_digit_en, 0);
        check("disable_seg", o_seg, 0);
        wait_cyc(2);
        check("idle_digit_en", o_digit_en, 0);
        check("idle_frame_done", o_frame_done, 0);

        // Re-enable restarts at digit 0 with a fresh value
        do_load(16'h9876, stall, fd_seen);
        wait_cyc(2);
        push_frame(4'h6, 7'h5F, 4'h7, 7'h70, 4'h8, 7'h7F, 4'h9, 7'h7B);
        enable_and_time("reenable");
        push_frame(4'h6, 7'h5F, 4'h7, 7'h70, 4'h8, 7'h7F, 4'h9, 7'h7B);

        // Load coincident with o_frame_done while pending is empty
        check("coincident_ready", o_load_ready, 1);
        i_load_valid = 1'b1;
        i_load_value = 16'h0000;
        wait_cyc(1);
        i_load_valid = 1'b0;
        check("coincident_captured", o_load_ready, 0);
`ifdef MEST_PRO_LEAD_ZERO_BLANK_EN
        gap_chk = 1'b0;
        push_ev(4'b0001, 4'h0, 7'h7E);
`else
        push_frame(4'h0, 7'h7E, 4'h0, 7'h7E, 4'h0, 7'h7E, 4'h0, 7'h7E);
`endif
        wait_fd(fd_n);

        // 0x0070: pending still holds 0x0000 for one more clock
        do_load(16'h0070, stall, fd_seen);
        check("load_0070_stall", stall, 1);
`ifdef MEST_PRO_LEAD_ZERO_BLANK_EN
        push_ev(4'b0001, 4'h0, 7'h7E);
        push_ev(4'b0010, 4'h7, 7'h70);
`else
        push_frame(4'h0, 7'h7E, 4'h7, 7'h70, 4'h0, 7'h7E, 4'h0, 7'h7E);
`endif
        wait_fd(fd_n);
        wait_fd(fd_n);

        // Reset mid-SHOW of digit 0 with a full pending buffer
        push_ev(4'b0001, 4'h0, 7'h7E);
        do_load(16'h1111, stall, fd_seen);
        wait_cyc(5);
        check("pre_rst_digit_en", o_digit_en, 4'b0001);
        check("pre_rst_ready", o_load_ready, 0);
        rst = 1'b1;
        #1;
        check("async_rst_digit_en", o_digit_en, 0);
        check("async_rst_seg", o_seg, 0);
        check("async_rst_digit_val", o_digit_val, 0);
        check("async_rst_frame_done", o_frame_done, 0);
        check("async_rst_ready", o_load_ready, 1);
        wait_cyc(2);
        rst = 1'b0;
        i_output_enable = 1'b0;
        wait_cyc(3);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
